// File: rtl/pixel_stream_receiver_pkg.sv
// Shared pixel/pair types and framing defaults for the dual-pixel RGB stream.
// Pair packing order is {R0,G0,B0,R1,G1,B1}; pixel 0 is the even column.
package pixel_stream_receiver_pkg;

  localparam int PIXEL_W        = 24;
  localparam int PAIR_W         = 48;
  localparam int DEFAULT_WIDTH  = 768;
  localparam int DEFAULT_HEIGHT = 512;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef struct packed {
    pixel_t p0;
    pixel_t p1;
  } pair_t;

  function automatic pair_t pack_pair(input pixel_t p0, input pixel_t p1);
    pair_t pr;
    pr.p0 = p0;
    pr.p1 = p1;
    return pr;
  endfunction

  function automatic pixel_t unpack_pixel(input pair_t pr, input logic sel);
    return sel ? pr.p1 : pr.p0;
  endfunction

endpackage

// File: rtl/pixel_pair_fifo.sv
// First-word-fall-through FIFO; dout is the head entry, registered write-to-read latency of one edge.
// Push while full is ignored unless a pop happens on the same edge.
module pixel_pair_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 48
) (
  input  logic                    core_clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage carries no reset: reset only needs to empty the pointers.
  always_ff @(posedge core_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_receiver.sv
// Buffers HSYNC-qualified pixel pairs and re-emits one pixel per clock with sol/eol/eof markers.
// First pixel visible the cycle after its push; out_ready low holds the current pixel and markers.
module pixel_stream_receiver
  import pixel_stream_receiver_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         HSYNC,
  input  logic [7:0]                   DATA_R0,
  input  logic [7:0]                   DATA_G0,
  input  logic [7:0]                   DATA_B0,
  input  logic [7:0]                   DATA_R1,
  input  logic [7:0]                   DATA_G1,
  input  logic [7:0]                   DATA_B1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_R,
  output logic [7:0]                   out_G,
  output logic [7:0]                   out_B,
  output logic                         out_sol,
  output logic                         out_eol,
  output logic                         out_eof,
  output logic                         frame_done,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  pair_t         wr_pair;
  pair_t         head;
  pixel_t        cur;
  logic          sel;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          full;
  logic          empty;
  logic          accept;
  logic          pop;
  logic          at_eol;
  logic          at_eof;

  assign wr_pair = pack_pair({DATA_R0, DATA_G0, DATA_B0}, {DATA_R1, DATA_G1, DATA_B1});

  pixel_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PAIR_W)
  ) u_fifo (
    .core_clk (HCLK),
    .rst      (HRESET),
    .push     (HSYNC),
    .pop      (pop),
    .din      (wr_pair),
    .dout     (head),
    .level    (fifo_level),
    .full     (full),
    .empty    (empty)
  );

  assign out_valid = !empty;
  assign accept    = out_valid && out_ready;
  assign pop       = accept && sel;
  assign cur       = unpack_pixel(head, sel);
  assign at_eol    = (col == CW'(WIDTH - 1));
  assign at_eof    = at_eol && (row == RW'(HEIGHT - 1));

  // Pixel and markers are forced to zero when idle so nothing stale leaks out after reset.
  assign out_R   = out_valid ? cur.r : 8'd0;
  assign out_G   = out_valid ? cur.g : 8'd0;
  assign out_B   = out_valid ? cur.b : 8'd0;
  assign out_sol = out_valid && (col == '0);
  assign out_eol = out_valid && at_eol;
  assign out_eof = out_valid && at_eof;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel        <= 1'b0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= accept && at_eof;
      if (HSYNC && full && !pop) overflow <= 1'b1;
      if (accept) begin
        sel <= ~sel;
        if (at_eol) begin
          col <= '0;
          row <= (row == RW'(HEIGHT - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Directed bench with a queue-based pixel model checked every cycle plus literal spot checks.
module tb_pixel_stream_receiver;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       HSYNC;
  logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic       out_valid, out_ready;
  logic [7:0] out_R, out_G, out_B;
  logic       out_sol, out_eol, out_eof, frame_done, overflow;
  logic [$clog2(D):0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_stream_receiver #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_R(out_R), .out_G(out_G), .out_B(out_B),
    .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof),
    .frame_done(frame_done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_pair(input logic [23:0] p0, input logic [23:0] p1);
    HSYNC = 1'b1;
    {DATA_R0, DATA_G0, DATA_B0} = p0;
    {DATA_R1, DATA_G1, DATA_B1} = p1;
  endtask

  // Model: stream of pending pixels in push order plus count of accepted pixels.
  logic [23:0] pix_q[$];
  int          n_acc = 0;
  bit          m_ovf = 1'b0;
  bit          m_fd  = 1'b0;

  always @(negedge HCLK) begin
    int  col, row, pairs;
    bit  acc, pop_pair, eof_now;
    if (HRESET) begin
      pix_q.delete();
      n_acc = 0;
      m_ovf = 1'b0;
      m_fd  = 1'b0;
    end
    pairs = (pix_q.size() + 1) / 2;
    col   = n_acc % W;
    row   = (n_acc / W) % H;
    check("m_valid", 32'(out_valid), 32'(pix_q.size() != 0));
    check("m_level", 32'(fifo_level), 32'(pairs));
    check("m_overflow", 32'(overflow), 32'(m_ovf));
    check("m_frame_done", 32'(frame_done), 32'(m_fd));
    eof_now = (col == W - 1) && (row == H - 1);
    if (pix_q.size() != 0) begin
      check("m_pixel", 32'({out_R, out_G, out_B}), 32'(pix_q[0]));
      check("m_sol", 32'(out_sol), 32'(col == 0));
      check("m_eol", 32'(out_eol), 32'(col == W - 1));
      check("m_eof", 32'(out_eof), 32'(eof_now));
    end
    if (!HRESET) begin
      acc      = (pix_q.size() != 0) && out_ready;
      pop_pair = acc && (pix_q.size() % 2 == 1);
      m_fd     = acc && eof_now;
      if (acc) begin
        void'(pix_q.pop_front());
        n_acc++;
      end
      if (HSYNC) begin
        if (pairs < D || pop_pair) begin
          pix_q.push_back({DATA_R0, DATA_G0, DATA_B0});
          pix_q.push_back({DATA_R1, DATA_G1, DATA_B1});
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [15:0] eolm, eofm;
    int k, fd_at, fd_cnt;
    HRESET = 1'b1; HSYNC = 1'b0; out_ready = 1'b0;
    drive_pair(24'h0, 24'h0);
    HSYNC = 1'b0;
    step(); step();
    @(negedge HCLK);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_sol", 32'(out_sol), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    step();
    HRESET = 1'b0;

    // Single pair
    out_ready = 1'b1;
    drive_pair(24'h112233, 24'h445566);
    step();
    HSYNC = 1'b0;
    @(negedge HCLK);
    check("single_valid0", 32'(out_valid), 1);
    check("single_pix0", 32'({out_R, out_G, out_B}), 32'h112233);
    check("single_sol0", 32'(out_sol), 1);
    step();
    @(negedge HCLK);
    check("single_pix1", 32'({out_R, out_G, out_B}), 32'h445566);
    check("single_sol1", 32'(out_sol), 0);
    step();
    @(negedge HCLK);
    check("single_empty", 32'(out_valid), 0);
    check("single_level", 32'(fifo_level), 0);
    step();

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_pair(24'hA0B0C0 + 24'(i) * 24'h010101, 24'hD0E0F0 + 24'(i) * 24'h010101);
      step();
    end
    HSYNC = 1'b0;
    repeat (10) step();
    @(negedge HCLK);
    check("bp_level", 32'(fifo_level), 4);
    check("bp_overflow", 32'(overflow), 0);
    check("bp_head", 32'({out_R, out_G, out_B}), 32'hA0B0C0);
    step();
    out_ready = 1'b1;
    repeat (8) step();
    @(negedge HCLK);
    check("bp_drained", 32'(fifo_level), 0);
    step();

    // Overflow and push-while-full-with-pop
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i));
      step();
    end
    HSYNC = 1'b0;
    @(negedge HCLK);
    check("ovf_level", 32'(fifo_level), 4);
    check("ovf_flag", 32'(overflow), 1);
    step();
    out_ready = 1'b1;
    step();
    drive_pair(24'h300007, 24'h400007);
    step();
    HSYNC = 1'b0;
    @(negedge HCLK);
    check("ovf_push_pop_level", 32'(fifo_level), 4);
    check("ovf_head_after_pop", 32'({out_R, out_G, out_B}), 32'h100001);
    repeat (10) step();

    // Mid-frame reset after 3 accepted pixels
    drive_pair(24'h0A0101, 24'h0A0202);
    step();
    drive_pair(24'h0B0101, 24'h0B0202);
    step();
    HSYNC = 1'b0;
    step(); step();
    HRESET = 1'b1;
    @(negedge HCLK);
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_level", 32'(fifo_level), 0);
    check("mrst_overflow", 32'(overflow), 0);
    check("mrst_pix", 32'({out_R, out_G, out_B}), 0);
    step();
    HRESET = 1'b0;
    drive_pair(24'h0C0101, 24'h0C0202);
    step();
    HSYNC = 1'b0;
    @(negedge HCLK);
    check("mrst_next_sol", 32'(out_sol), 1);
    check("mrst_next_pix", 32'({out_R, out_G, out_B}), 32'h0C0101);
    step(); step(); step();

    // Framing over one full 4x2 frame
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    k = 0; eolm = '0; eofm = '0; fd_at = -1; fd_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 4) drive_pair(24'h500000 + 24'(2 * c), 24'h500001 + 24'(2 * c));
      else HSYNC = 1'b0;
      @(negedge HCLK);
      if (frame_done) begin
        fd_cnt++;
        fd_at = k;
      end
      if (out_valid && out_ready) begin
        if (k < 16 && out_eol) eolm[k] = 1'b1;
        if (k < 16 && out_eof) eofm[k] = 1'b1;
        k++;
      end
      step();
    end
    check("frm_count", 32'(k), 8);
    check("frm_eol_mask", 32'(eolm), 32'h0088);
    check("frm_eof_mask", 32'(eofm), 32'h0080);
    check("frm_done_count", 32'(fd_cnt), 1);
    check("frm_done_at", 32'(fd_at), 8);
    drive_pair(24'h600000, 24'h600001);
    step();
    HSYNC = 1'b0;
    @(negedge HCLK);
    check("frm_next_sol", 32'(out_sol), 1);
    check("frm_next_eol", 32'(out_eol), 0);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_stream_receiver.md
Name: pixel_stream_receiver

Overview:
- Receive end of the dual-pixel RGB stream driven by image_read: HSYNC-qualified, two 24-bit pixels per clock.
- Buffers pixel pairs in a small FIFO and re-emits them as one pixel per clock on a valid/ready interface, with line and frame markers.
- Sits between the image source and any synthesizable downstream filter/sink that cannot sustain two pixels per clock or needs backpressure.

Parameters:
- WIDTH, 768, pixels per line; even, >= 2.
- HEIGHT, 512, lines per frame; >= 1.
- FIFO_DEPTH, 16, pixel-pair entries; power of 2, >= 2.

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSYNC  in  1  pair-valid; DATA_* sampled when high.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  first (even-column) pixel of the pair.
- DATA_R1, DATA_G1, DATA_B1  in  8 each  second (odd-column) pixel of the pair.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_R, out_G, out_B  out  8 each  output pixel.
- out_sol  out  1  qualifies pixel at column 0.
- out_eol  out  1  qualifies pixel at column WIDTH-1.
- out_eof  out  1  qualifies last pixel of frame (column WIDTH-1, row HEIGHT-1).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- overflow  out  1  sticky; a pair arrived while the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current pair count.

Behaviour:
- Reset: all outputs 0, FIFO empty, column/row counters 0, sub-pixel select 0, overflow cleared. Reset asserted mid-frame discards buffered data; the next accepted pixel after release is column 0, row 0.
- Push: on an edge with HSYNC=1, write the 48-bit pair {R0,G0,B0,R1,G1,B1}.
- Push when full:
  - No pop in the same cycle: pair dropped, overflow set until reset.
  - Pop in the same cycle: push accepted, level unchanged.
- Output latency: a pair pushed at edge N asserts out_valid after edge N (visible in cycle N+1) when the FIFO was empty. No combinational path from HSYNC or DATA_* to outputs.
- Serializer: sub-pixel select sel.
  - sel=0 presents pixel 0 of the head entry; sel=1 presents pixel 1.
  - Accept with sel=0: sel becomes 1.
  - Accept with sel=1: sel becomes 0 and the head entry is popped.
  - out_valid = (level != 0).
- Stability: while out_valid && !out_ready, out_R/G/B and the markers are held stable.
- Counters advance only on accept:
  - col wraps WIDTH-1 -> 0, incrementing row.
  - row wraps HEIGHT-1 -> 0.
- Markers (combinational on counters, only meaningful with out_valid):
  - out_sol = (col==0).
  - out_eol = (col==WIDTH-1).
  - out_eof = out_eol && row==HEIGHT-1.
- frame_done: registered; high for exactly one cycle following the accept of the out_eof pixel.
- Dropped pairs do not advance counters; framing is by accepted-pixel count only.
- Level arithmetic: push-only +1, pop-only -1, push+pop or neither unchanged; never exceeds FIFO_DEPTH, never underflows.

Decomposition:
- Shared package:
  - PIXEL_W=24, PAIR_W=48.
  - Pixel and pixel-pair typedefs with pack/unpack functions matching R0,G0,B0,R1,G1,B1 ordering.
  - Default WIDTH/HEIGHT constants shared with the image source and writer.
- Sub-module pixel_pair_fifo:
  - Synchronous FIFO (PAIR_W x FIFO_DEPTH), first-word-fall-through.
  - Ports: push, pop, din, dout, level, full, empty.
  - Same async active-high reset.
- Top level holds the serializer, the counters, frame_done and overflow.

Test Plan:
- Single pair: HSYNC=1 one cycle with pixels 0x112233/0x445566, out_ready=1 -> out_valid cycles N+1 and N+2 showing 0x112233 then 0x445566; first has out_sol=1; level returns to 0.
- Backpressure: push 4 pairs, out_ready=0 for 10 cycles -> outputs stable, level=4, no overflow; release -> 8 pixels in push order.
- Overflow: FIFO_DEPTH=4, out_ready=0, 6 consecutive pushes -> level=4, overflow=1, pairs 5-6 lost; out_ready=1 with push on the same cycle as a full-state pop -> level stays 4.
- Framing: WIDTH=4, HEIGHT=2, 4 pairs streamed, out_ready=1 -> out_eol at pixels 3 and 7, out_eof only at pixel 7, frame_done one cycle after; next pixel has col=0, row=0, out_sol=1.
- Mid-frame reset: after 3 accepted pixels assert HRESET for 1 cycle -> all outputs 0, level=0, overflow=0; the next pair is emitted as column 0 with out_sol=1.
